param_stack: RTL and testbench
==============================

PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits (min 1).
REQ-002 The block SHALL have parameter DEPTH, default 1024, maximum number of stored entries (min 2).
REQ-003 The block SHALL define the local width CW = $clog2(DEPTH+1), the bits needed to hold a count of 0..DEPTH.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 Port: push  input  1  level-sampled push request, one push per asserted cycle.
REQ-007 Port: pop  input  1  level-sampled pop request, one pop per asserted cycle.
REQ-008 Port: clear  input  1  synchronous flush, emptying the stack without reset.
REQ-009 Port: d_in  input  WIDTH  data written on push.
REQ-010 Port: d_out  output  WIDTH  top-of-stack entry; 0 when empty.
REQ-011 Port: d_next  output  WIDTH  entry below top; 0 when count < 2.
REQ-012 Port: count  output  CW  number of valid entries.
REQ-013 Port: empty  output  1  high when count == 0.
REQ-014 Port: full  output  1  high when count == DEPTH.
REQ-015 Port: overflow  output  1  one-cycle registered pulse flagging a rejected push.
REQ-016 Port: underflow  output  1  one-cycle registered pulse flagging a rejected pop.

Function
REQ-017 The stack SHALL hold its entries in a DEPTH x WIDTH storage array.
REQ-018 The stack pointer SHALL equal count, and the top entry SHALL sit at index count-1.
REQ-019 d_out, d_next, empty and full SHALL be combinational from the current count and storage, with zero-cycle read latency.
REQ-020 A push alone while not full SHALL write d_in to index count and increment count, so the new data appears on d_out the next cycle.
REQ-021 A pop alone while not empty SHALL decrement count, and SHALL NOT alter the storage contents.
REQ-022 A push alone while full SHALL leave count and storage unchanged and SHALL assert overflow for exactly the next cycle.
REQ-023 A pop alone while empty SHALL leave count unchanged and SHALL assert underflow for exactly the next cycle.
REQ-024 Push and pop together while not empty (including full) SHALL replace the top entry with d_in, leave count unchanged, and raise neither error flag.
REQ-025 Push and pop together while empty SHALL act as a push alone, with no underflow.
REQ-026 clear SHALL set count to 0, override push and pop in the same cycle, and raise neither error flag.
REQ-027 overflow and underflow SHALL be low in every cycle not covered by REQ-022 or REQ-023.
REQ-028 count SHALL never exceed DEPTH, never go below 0, and never wrap around.
REQ-029 Storage writes SHALL occur only under REQ-020, REQ-024 or REQ-025.

Reset
REQ-030 When rst is high at a clock edge, count SHALL become 0, overflow and underflow SHALL become 0, and rst SHALL take priority over clear, push and pop.
REQ-031 After reset, d_out and d_next SHALL read 0, empty SHALL be 1 and full SHALL be 0.
REQ-032 Storage contents SHALL NOT be reset, and stale data SHALL never be visible because of REQ-010 and REQ-011.
REQ-033 Reset asserted mid-sequence (stack partially filled) SHALL yield the REQ-031 state on the following cycle, with any concurrent push discarded.

Verification
REQ-034 Fill/drain (WIDTH=8, DEPTH=4): push 0x11,0x22,0x33,0x44 -> count=4, full=1, d_out=0x44, d_next=0x33; then 4 pops -> d_out sequence 0x33,0x22,0x11,0x00 and empty=1.
REQ-035 Overflow: with the stack full, push 0x55 -> overflow=1 for one cycle, count=4, d_out=0x44.
REQ-036 Underflow: with the stack empty, pop -> underflow=1 for one cycle, count=0, d_out=0x00.
REQ-037 Simultaneous events: with count=2 and top=0x22, push 0x99 with pop -> count=2, d_out=0x99, d_next=0x11; with the stack empty, push 0x7 with pop -> count=1, d_out=0x07.
REQ-038 Clear and reset: with count=3, clear with push -> count=0, no flags; refill to count=2, then rst with push 0xAA -> count=0, d_out=0, empty=1.
REQ-039 Random push/pop/clear sequences SHALL match a reference queue model every cycle, for both DEPTH=4 and DEPTH=1024 and for WIDTH=1 and WIDTH=32.

Source files
------------

// File: rtl/param_stack.sv
// LIFO stack of DEPTH x WIDTH words; top and next-below entries read combinationally (zero-cycle latency).
// No backpressure: rejected push/pop leave state intact and raise a one-cycle overflow/underflow pulse.
module param_stack #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 1024,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] d_next,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int            IW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_replace;
    logic             w_wr_en;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_next_idx;
    logic [IW-1:0]    w_wr_idx;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_top_idx  = IW'(r_count - CW'(1));
    assign w_next_idx = IW'(r_count - CW'(2));

    // Push with pop on a non-empty stack overwrites the top in place, even when full.
    assign w_replace = push && pop && !w_empty;
    assign w_wr_en   = !rst && !clear && push && (w_replace || !w_full);
    assign w_wr_idx  = w_replace ? w_top_idx : IW'(r_count);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            if (clear) begin
                r_count <= '0;
            end else if (w_replace) begin
                r_count <= r_count;
            end else if (push) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                end else begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Storage is never reset; gating on count keeps stale words off the outputs.
    assign d_out     = w_empty ? '0 : r_mem[w_top_idx];
    assign d_next    = (r_count < CW'(2)) ? '0 : r_mem[w_next_idx];
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack: directed scenarios plus random push/pop/clear against a queue model,
// driving three instances (8x4, 32x1024, 1x4) from one shared stimulus stream.
module tb_param_stack;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, push, pop, clear;
    logic [31:0] din;

    logic [7:0]  a_dout, a_dnext;
    logic [2:0]  a_cnt;
    logic        a_e, a_f, a_o, a_u;
    logic [31:0] b_dout, b_dnext;
    logic [10:0] b_cnt;
    logic        b_e, b_f, b_o, b_u;
    logic        c_dout, c_dnext;
    logic [2:0]  c_cnt;
    logic        c_e, c_f, c_o, c_u;

    param_stack #(.WIDTH(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear), .d_in(din[7:0]),
        .d_out(a_dout), .d_next(a_dnext), .count(a_cnt), .empty(a_e), .full(a_f),
        .overflow(a_o), .underflow(a_u)
    );

    param_stack #(.WIDTH(32), .DEPTH(1024)) u_big (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear), .d_in(din),
        .d_out(b_dout), .d_next(b_dnext), .count(b_cnt), .empty(b_e), .full(b_f),
        .overflow(b_o), .underflow(b_u)
    );

    param_stack #(.WIDTH(1), .DEPTH(4)) u_w1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear), .d_in(din[0]),
        .d_out(c_dout), .d_next(c_dnext), .count(c_cnt), .empty(c_e), .full(c_f),
        .overflow(c_o), .underflow(c_u)
    );

    logic [31:0] ob_cnt [3];
    logic [31:0] ob_do  [3];
    logic [31:0] ob_dn  [3];
    logic        ob_e   [3];
    logic        ob_f   [3];
    logic        ob_o   [3];
    logic        ob_u   [3];

    assign ob_cnt[0] = {29'b0, a_cnt};
    assign ob_cnt[1] = {21'b0, b_cnt};
    assign ob_cnt[2] = {29'b0, c_cnt};
    assign ob_do[0]  = {24'b0, a_dout};
    assign ob_do[1]  = b_dout;
    assign ob_do[2]  = {31'b0, c_dout};
    assign ob_dn[0]  = {24'b0, a_dnext};
    assign ob_dn[1]  = b_dnext;
    assign ob_dn[2]  = {31'b0, c_dnext};
    assign ob_e[0] = a_e;  assign ob_e[1] = b_e;  assign ob_e[2] = c_e;
    assign ob_f[0] = a_f;  assign ob_f[1] = b_f;  assign ob_f[2] = c_f;
    assign ob_o[0] = a_o;  assign ob_o[1] = b_o;  assign ob_o[2] = c_o;
    assign ob_u[0] = a_u;  assign ob_u[1] = b_u;  assign ob_u[2] = c_u;

    int          checks = 0;
    int          errors = 0;
    int          md [3] = '{4, 1024, 4};
    logic [31:0] mm [3] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] mq [3][$];
    logic        eo [3];
    logic        eu [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a plain queue whose back is the top of the stack.
    task automatic model_step(input logic p, input logic po, input logic c, input logic r,
                              input logic [31:0] d);
        for (int k = 0; k < 3; k++) begin
            int n;
            n = mq[k].size();
            eo[k] = 1'b0;
            eu[k] = 1'b0;
            if (r || c) begin
                mq[k].delete();
            end else if (p && po && n > 0) begin
                mq[k][n-1] = d & mm[k];
            end else if (p) begin
                if (n < md[k]) mq[k].push_back(d & mm[k]);
                else           eo[k] = 1'b1;
            end else if (po) begin
                if (n > 0) void'(mq[k].pop_back());
                else       eu[k] = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 3; k++) begin
            int          n;
            logic [31:0] etop, enext;
            n     = mq[k].size();
            etop  = (n > 0) ? mq[k][n-1] : 32'h0;
            enext = (n > 1) ? mq[k][n-2] : 32'h0;
            chk($sformatf("k%0d_count", k), ob_cnt[k], 32'(n));
            chk($sformatf("k%0d_d_out", k), ob_do[k], etop);
            chk($sformatf("k%0d_d_next", k), ob_dn[k], enext);
            chk($sformatf("k%0d_empty", k), {31'b0, ob_e[k]}, {31'b0, n == 0});
            chk($sformatf("k%0d_full", k), {31'b0, ob_f[k]}, {31'b0, n == md[k]});
            chk($sformatf("k%0d_overflow", k), {31'b0, ob_o[k]}, {31'b0, eo[k]});
            chk($sformatf("k%0d_underflow", k), {31'b0, ob_u[k]}, {31'b0, eu[k]});
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are checked 1 unit after the next edge.
    task automatic step(input logic p, input logic po, input logic c, input logic r,
                        input logic [31:0] d);
        push = p; pop = po; clear = c; rst = r; din = d;
        @(posedge clk);
        #1;
        model_step(p, po, c, r, d);
        check_model();
    endtask

    initial begin
        push = 0; pop = 0; clear = 0; rst = 1; din = 0;
        step(0, 0, 0, 1, 0);
        chk("rst_count", {29'b0, a_cnt}, 32'd0);
        chk("rst_empty", {31'b0, a_e}, 32'd1);
        chk("rst_d_out", {24'b0, a_dout}, 32'd0);

        // Fill / drain
        step(1, 0, 0, 0, 32'h11);
        step(1, 0, 0, 0, 32'h22);
        step(1, 0, 0, 0, 32'h33);
        step(1, 0, 0, 0, 32'h44);
        chk("fill_count", {29'b0, a_cnt}, 32'd4);
        chk("fill_full", {31'b0, a_f}, 32'd1);
        chk("fill_d_out", {24'b0, a_dout}, 32'h44);
        chk("fill_d_next", {24'b0, a_dnext}, 32'h33);
        step(0, 1, 0, 0, 0); chk("drain1", {24'b0, a_dout}, 32'h33);
        step(0, 1, 0, 0, 0); chk("drain2", {24'b0, a_dout}, 32'h22);
        step(0, 1, 0, 0, 0); chk("drain3", {24'b0, a_dout}, 32'h11);
        step(0, 1, 0, 0, 0); chk("drain4", {24'b0, a_dout}, 32'h00);
        chk("drain_empty", {31'b0, a_e}, 32'd1);

        // Underflow
        step(0, 1, 0, 0, 0);
        chk("unf_flag", {31'b0, a_u}, 32'd1);
        chk("unf_count", {29'b0, a_cnt}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("unf_drop", {31'b0, a_u}, 32'd0);

        // Overflow
        step(1, 0, 0, 0, 32'h11);
        step(1, 0, 0, 0, 32'h22);
        step(1, 0, 0, 0, 32'h33);
        step(1, 0, 0, 0, 32'h44);
        step(1, 0, 0, 0, 32'h55);
        chk("ovf_flag", {31'b0, a_o}, 32'd1);
        chk("ovf_count", {29'b0, a_cnt}, 32'd4);
        chk("ovf_d_out", {24'b0, a_dout}, 32'h44);
        step(0, 0, 0, 0, 0);
        chk("ovf_drop", {31'b0, a_o}, 32'd0);
        step(1, 1, 0, 0, 32'h66);
        chk("full_replace", {24'b0, a_dout}, 32'h66);
        chk("full_replace_ovf", {31'b0, a_o}, 32'd0);

        // Simultaneous push+pop
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 32'h11);
        step(1, 0, 0, 0, 32'h22);
        step(1, 1, 0, 0, 32'h99);
        chk("pp_count", {29'b0, a_cnt}, 32'd2);
        chk("pp_d_out", {24'b0, a_dout}, 32'h99);
        chk("pp_d_next", {24'b0, a_dnext}, 32'h11);
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 32'h07);
        chk("pp_empty_count", {29'b0, a_cnt}, 32'd1);
        chk("pp_empty_d_out", {24'b0, a_dout}, 32'h07);
        chk("pp_empty_unf", {31'b0, a_u}, 32'd0);

        // Clear and mid-sequence reset
        step(1, 0, 0, 0, 32'h21);
        step(1, 0, 0, 0, 32'h31);
        step(1, 0, 1, 0, 32'h41);
        chk("clr_count", {29'b0, a_cnt}, 32'd0);
        chk("clr_flags", {30'b0, a_o, a_u}, 32'd0);
        step(1, 0, 0, 0, 32'h12);
        step(1, 0, 0, 0, 32'h13);
        step(1, 0, 0, 1, 32'hAA);
        chk("rst_mid_count", {29'b0, a_cnt}, 32'd0);
        chk("rst_mid_d_out", {24'b0, a_dout}, 32'd0);
        chk("rst_mid_empty", {31'b0, a_e}, 32'd1);

        // Random: push-biased phase lets the deep instance reach full, then a pop-biased phase.
        for (int i = 0; i < 6000; i++) begin
            logic p, po, c, r;
            int   pp;
            pp = (i < 3000) ? 75 : 30;
            p  = ($urandom_range(99) < pp);
            po = ($urandom_range(99) < 100 - pp);
            c  = ($urandom_range(1999) == 0);
            r  = ($urandom_range(2999) == 0);
            step(p, po, c, r, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
